// File: rtl/if_fetch_unit.sv
// Instruction fetch: drives the ROM and queues {pc, instr} pairs toward decode over valid/ready.
// Latency: a word read in cycle N reaches the queue head at N+1 at the earliest (registered storage, no bypass).
// Backpressure: id_ready low fills the queue and then holds pc; a redirect flushes the queue and refetches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       rom_ce,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_instr,
    output logic [31:0]                id_pc,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    fq_entry_t        fq_mem [FQ_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [31:0]      pc;
    logic             push;
    logic             pop;
    logic             fq_full;

    assign fq_full  = (count == DEPTH_C);
    assign pop      = id_valid & id_ready;
    // A full queue may still accept a word when decode drains the head in the same cycle.
    assign push     = rom_ce & ~redirect_valid & (~fq_full | pop);

    assign rom_addr = {pc[31:2], 2'b00};
    assign id_valid = (count != '0);
    assign id_instr = fq_mem[rd_ptr].instr;
    assign id_pc    = fq_mem[rd_ptr].pc;
    assign fq_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_ce <= 1'b0;
            pc     <= RESET_PC;
        end else begin
            rom_ce <= 1'b1;
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                pc <= pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            // A head popped this cycle is still consumed by decode; everything else is dropped.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_mem[i] <= '0;
            end
        end else if (push) begin
            fq_mem[wr_ptr] <= {pc, rom_instr};
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized traffic,
// checked against a queue-based model of the fetch behaviour.
module tb_if_fetch_unit;

    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [$clog2(FQ_DEPTH):0] fq_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic        m_ce;
    logic [31:0] m_pc;
    logic [31:0] acc[$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_instr(rom_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .fq_count(fq_count)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h3422_9C98;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_instr = rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i >= acc.size()) return 32'hDEAD_BEEF;
        return acc[i];
    endfunction

    task automatic model_reset();
        m_ce = 1'b0;
        m_pc = RESET_PC;
        mq.delete();
    endtask

    task automatic check_model();
        chk("rom_ce", 32'(rom_ce), 32'(m_ce));
        chk("rom_addr", rom_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
        chk("fq_count", 32'(fq_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("id_pc", id_pc, mq[0].pc);
            chk("id_instr", id_instr, mq[0].instr);
        end
    endtask

    task automatic model_update(input logic rv, input logic [31:0] rp, input logic rdy);
        ent_t e;
        if (rv) begin
            mq.delete();
            m_pc = {rp[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (m_ce && mq.size() < FQ_DEPTH) begin
                e.pc = m_pc;
                e.instr = rom_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
        check_model();
        redirect_valid = rv;
        redirect_pc = rp;
        id_ready = rdy;
        if (id_valid && rdy) acc.push_back(id_pc);
        model_update(rv, rp, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        acc.delete();
    endtask

    initial begin
        // Reset state while reset is asserted
        @(negedge clk);
        chk("rst_rom_ce", 32'(rom_ce), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_fq_count", 32'(fq_count), 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_rom_addr", rom_addr, RESET_PC);

        // Streaming with decode always ready
        do_reset();
        chk("t1_valid_c0", 32'(id_valid), 32'h0);
        step(1'b0, '0, 1'b1);
        chk("t1_valid_c1", 32'(id_valid), 32'h0);
        step(1'b0, '0, 1'b1);
        chk("t1_valid_c2", 32'(id_valid), 32'h1);
        chk("t1_instr0", id_instr, 32'h3422_9C98);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("t1_nacc", acc.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_acc", acc_at(i), 32'(i * 4));

        // Decode stall: queue saturates, pc holds, then drains in order
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        chk("t2_full", 32'(fq_count), 32'h2);
        chk("t2_addr", rom_addr, 32'h8);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("t2_nacc", acc.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_acc", acc_at(i), 32'(i * 4));

        // Redirect with a full queue flushes it
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h40, 1'b0);
        chk("t3_cnt0", 32'(fq_count), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("t3_acc0", acc_at(0), 32'h40);
        chk("t3_acc1", acc_at(1), 32'h44);

        // Unaligned target and address wrap
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        acc.delete();
        step(1'b1, 32'h43, 1'b0);
        chk("t4_addr", rom_addr, 32'h40);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t4_acc0", acc_at(0), 32'h40);
        acc.delete();
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("t4_wrap0", acc_at(0), 32'hFFFF_FFFC);
        chk("t4_wrap1", acc_at(1), 32'h0);

        // Redirect in the same cycle that decode pops pc 0x8
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t5_head8", id_pc, 32'h8);
        step(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("t5_acc2", acc_at(2), 32'h8);
        chk("t5_acc3", acc_at(3), 32'h100);

        // Asynchronous reset during a stall with a full queue
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        chk("t6_full", 32'(fq_count), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rom_ce", 32'(rom_ce), 32'h0);
        chk("t6_valid", 32'(id_valid), 32'h0);
        chk("t6_count", 32'(fq_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        acc.delete();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("t6_restart", acc_at(0), RESET_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic        rdy;
            logic [31:0] rp;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 15) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 255));
            step(rv, rp, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
